// File: rtl/display_mode_sequencer.sv
// Frame-synchronous display mode sequencer: arbitrates host, button and auto-cycle requests,
// blanks video across the switch and hands the new mode to the generators via a load handshake.
module display_mode_sequencer #(
    parameter int AUTO_FRAMES  = 300,
    parameter int BLANK_FRAMES = 2,
    parameter int ACK_TIMEOUT  = 1023
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    output logic       cmd_ready,
    input  logic       frame_start,
    input  logic       gen_ack,
    output logic [1:0] mode_sel,
    output logic       load_req,
    output logic       blank,
    output logic       busy,
    output logic       err_pulse
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRM,
        S_BLANK,
        S_LOAD,
        S_UNBLANK
    } state_t;

    localparam logic [11:0] FRM_LAST = 12'(AUTO_FRAMES - 1);
    localparam logic [3:0]  BLK_LAST = 4'(BLANK_FRAMES - 1);
    localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [11:0] frm_cnt;
    logic [3:0]  blk_cnt;
    logic [15:0] to_cnt;
    logic [1:0]  pend_mode;
    logic [1:0]  prev_mode;

    logic        cmd_xfer;
    logic        auto_tick;
    logic        capture;
    logic        req_switch;
    logic [1:0]  req_target;

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        case (m)
            2'd1:    next_mode = 2'd2;
            2'd2:    next_mode = 2'd3;
            default: next_mode = 2'd1;
        endcase
    endfunction

    // Request arbitration: host command beats button beats auto tick; losers are dropped.
    always_comb begin
        cmd_xfer   = cmd_valid & cmd_ready & (state == S_IDLE);
        auto_tick  = (state == S_IDLE) & auto_en & frame_start & (frm_cnt == FRM_LAST);
        capture    = (state == S_IDLE) & (cmd_xfer | btn_next | auto_tick);
        req_target = next_mode(mode_sel);
        req_switch = 1'b1;
        if (cmd_xfer) begin
            req_target = cmd_mode;
            req_switch = (cmd_mode != 2'd0) && (cmd_mode != mode_sel);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            mode_sel  <= 2'd1;
            load_req  <= 1'b0;
            blank     <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            err_pulse <= 1'b0;
            frm_cnt   <= 12'd0;
            blk_cnt   <= 4'd0;
            to_cnt    <= 16'd0;
            pend_mode <= 2'd1;
            prev_mode <= 2'd1;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!auto_en || capture) begin
                        frm_cnt <= 12'd0;
                    end else if (frame_start) begin
                        frm_cnt <= frm_cnt + 12'd1;
                    end
                    if (cmd_xfer && (cmd_mode == 2'd0)) begin
                        err_pulse <= 1'b1;
                    end
                    if (capture && req_switch) begin
                        pend_mode <= req_target;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= S_WAIT_FRM;
                    end
                end
                S_WAIT_FRM: begin
                    if (frame_start) begin
                        blank   <= 1'b1;
                        blk_cnt <= 4'd0;
                        state   <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (frame_start) begin
                        if (blk_cnt == BLK_LAST) begin
                            prev_mode <= mode_sel;
                            mode_sel  <= pend_mode;
                            load_req  <= 1'b1;
                            to_cnt    <= 16'd0;
                            state     <= S_LOAD;
                        end else begin
                            blk_cnt <= blk_cnt + 4'd1;
                        end
                    end
                end
                S_LOAD: begin
                    // An acknowledge in the final timeout cycle still counts as success.
                    if (gen_ack) begin
                        load_req <= 1'b0;
                        state    <= S_UNBLANK;
                    end else if (to_cnt == TO_LAST) begin
                        load_req  <= 1'b0;
                        mode_sel  <= prev_mode;
                        err_pulse <= 1'b1;
                        state     <= S_UNBLANK;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_UNBLANK: begin
                    if (frame_start) begin
                        blank     <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        frm_cnt   <= 12'd0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Randomised, self-checking bench for display_mode_sequencer with a frame-level reference model.
module tb_display_mode_sequencer;

    localparam int AUTO_FRAMES  = 4;
    localparam int BLANK_FRAMES = 2;
    localparam int ACK_TIMEOUT  = 1023;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       btn_next = 1'b0;
    logic       auto_en = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_mode = 2'd0;
    logic       cmd_ready;
    logic       frame_start = 1'b0;
    logic       gen_ack = 1'b0;
    logic [1:0] mode_sel;
    logic       load_req;
    logic       blank;
    logic       busy;
    logic       err_pulse;

    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] exp_mode = 2'd1;

    display_mode_sequencer #(
        .AUTO_FRAMES (AUTO_FRAMES),
        .BLANK_FRAMES(BLANK_FRAMES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .btn_next   (btn_next),
        .auto_en    (auto_en),
        .cmd_valid  (cmd_valid),
        .cmd_mode   (cmd_mode),
        .cmd_ready  (cmd_ready),
        .frame_start(frame_start),
        .gen_ack    (gen_ack),
        .mode_sel   (mode_sel),
        .load_req   (load_req),
        .blank      (blank),
        .busy       (busy),
        .err_pulse  (err_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    // Mode rotation 1->2->3->1 as plain modular arithmetic.
    function automatic logic [1:0] succ(input logic [1:0] m);
        return 2'((32'(m) % 3) + 1);
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic apply_reset();
        btn_next = 1'b0; cmd_valid = 1'b0; frame_start = 1'b0; gen_ack = 1'b0; auto_en = 1'b0;
        sys_rst_n = 1'b0;
        #3;
        step();
        step();
        sys_rst_n = 1'b1;
        step();
    endtask

    // Drives a full switch after a captured request and records what the DUT showed.
    task automatic drive_switch(input int gap, input int ack_dly, output logic b1, output logic ld,
                                output logic [1:0] md, output logic ld_post, output logic b_fin,
                                output logic busy_fin, output logic [1:0] md_fin);
        idle(gap);
        frame();
        b1 = blank;
        for (int i = 0; i < BLANK_FRAMES; i++) begin
            idle(gap);
            frame();
        end
        ld = load_req;
        md = mode_sel;
        idle(ack_dly);
        gen_ack = 1'b1;
        step();
        gen_ack = 1'b0;
        ld_post = load_req;
        idle(gap);
        frame();
        b_fin = blank;
        busy_fin = busy;
        md_fin = mode_sel;
    endtask

    task automatic test_reset();
        #1 sys_rst_n = 1'b0;
        #1;
        vectors++;
        if ({mode_sel, load_req, blank, busy, cmd_ready, err_pulse} !== 7'b01_0001_0) begin
            miscompares++;
            $display("FAIL reset_async: got %b want %b",
                     {mode_sel, load_req, blank, busy, cmd_ready, err_pulse}, 7'b01_0001_0);
        end
        step();
        step();
        sys_rst_n = 1'b1;
        idle(3);
        vectors++;
        if ({mode_sel, load_req, blank, busy, cmd_ready, err_pulse} !== 7'b01_0001_0) begin
            miscompares++;
            $display("FAIL reset_release: got %b want %b",
                     {mode_sel, load_req, blank, busy, cmd_ready, err_pulse}, 7'b01_0001_0);
        end
        exp_mode = 2'd1;
    endtask

    task automatic test_button();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        vectors++;
        if ({busy, cmd_ready, blank} !== 3'b100) begin
            miscompares++;
            $display("FAIL btn_capture: got busy/ready/blank=%b want 100", {busy, cmd_ready, blank});
        end
        idle(99);
        vectors++;
        if (blank !== 1'b0) begin
            miscompares++;
            $display("FAIL btn_blank_early: got %b want 0", blank);
        end
        frame();
        vectors++;
        if (blank !== 1'b1) begin
            miscompares++;
            $display("FAIL btn_blank_rise: got %b want 1", blank);
        end
        idle(99);
        frame();
        vectors++;
        if ({mode_sel, load_req} !== {2'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL btn_frame2: got mode/load=%b want 010", {mode_sel, load_req});
        end
        idle(99);
        frame();
        vectors++;
        if ({mode_sel, load_req} !== {2'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL btn_load: got mode/load=%b want 101", {mode_sel, load_req});
        end
        step();
        step();
        gen_ack = 1'b1;
        step();
        gen_ack = 1'b0;
        vectors++;
        if ({load_req, blank, err_pulse, mode_sel} !== {3'b010, 2'd2}) begin
            miscompares++;
            $display("FAIL btn_ack: got load/blank/err/mode=%b want 01010", {load_req, blank, err_pulse, mode_sel});
        end
        idle(99);
        frame();
        vectors++;
        if ({blank, busy, cmd_ready, mode_sel} !== {3'b001, 2'd2}) begin
            miscompares++;
            $display("FAIL btn_unblank: got blank/busy/ready/mode=%b want 00110", {blank, busy, cmd_ready, mode_sel});
        end
        exp_mode = 2'd2;
    endtask

    task automatic test_priority();
        logic b1, ld, ld_post, b_fin, busy_fin;
        logic [1:0] md, md_fin;
        cmd_valid = 1'b1;
        cmd_mode = 2'd3;
        btn_next = 1'b1;
        step();
        cmd_valid = 1'b0;
        btn_next = 1'b0;
        step();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        drive_switch(8, 2, b1, ld, md, ld_post, b_fin, busy_fin, md_fin);
        vectors++;
        if ({b1, ld, md, ld_post} !== {2'b11, 2'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_load: got blank/load/mode/load_after=%b want 11110", {b1, ld, md, ld_post});
        end
        vectors++;
        if ({b_fin, busy_fin, md_fin} !== {2'b00, 2'd3}) begin
            miscompares++;
            $display("FAIL prio_final: got blank/busy/mode=%b want 0011", {b_fin, busy_fin, md_fin});
        end
        for (int i = 0; i < 4; i++) begin
            idle(5);
            frame();
        end
        vectors++;
        if ({busy, blank, mode_sel} !== {2'b00, 2'd3}) begin
            miscompares++;
            $display("FAIL prio_no_second: got busy/blank/mode=%b want 0011", {busy, blank, mode_sel});
        end
        exp_mode = 2'd3;
    endtask

    task automatic test_illegal_cmd();
        cmd_valid = 1'b1;
        cmd_mode = 2'd0;
        step();
        cmd_valid = 1'b0;
        vectors++;
        if ({err_pulse, busy, mode_sel} !== {2'b10, exp_mode}) begin
            miscompares++;
            $display("FAIL illegal_err: got err/busy/mode=%b want %b", {err_pulse, busy, mode_sel}, {2'b10, exp_mode});
        end
        step();
        vectors++;
        if (err_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_single: got %b want 0", err_pulse);
        end
        cmd_valid = 1'b1;
        cmd_mode = exp_mode;
        step();
        cmd_valid = 1'b0;
        vectors++;
        if ({err_pulse, busy, cmd_ready, mode_sel} !== {3'b001, exp_mode}) begin
            miscompares++;
            $display("FAIL same_mode: got err/busy/ready/mode=%b want %b",
                     {err_pulse, busy, cmd_ready, mode_sel}, {3'b001, exp_mode});
        end
        idle(3);
        frame();
        vectors++;
        if ({busy, blank} !== 2'b00) begin
            miscompares++;
            $display("FAIL same_mode_noswitch: got busy/blank=%b want 00", {busy, blank});
        end
    endtask

    task automatic test_auto_cycle();
        logic b1, ld, ld_post, b_fin, busy_fin;
        logic [1:0] md, md_fin;
        apply_reset();
        exp_mode = 2'd1;
        auto_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int f = 0; f < AUTO_FRAMES - 1; f++) begin
                idle(4);
                frame();
            end
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL auto_early_tick: round %0d got busy %b want 0", k, busy);
            end
            idle(4);
            frame();
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL auto_tick: round %0d got busy %b want 1", k, busy);
            end
            drive_switch(6, 1, b1, ld, md, ld_post, b_fin, busy_fin, md_fin);
            vectors++;
            if ({md, md_fin, busy_fin, b_fin} !== {succ(exp_mode), succ(exp_mode), 2'b00}) begin
                miscompares++;
                $display("FAIL auto_mode: round %0d got mode/final/busy/blank=%b want %b", k,
                         {md, md_fin, busy_fin, b_fin}, {succ(exp_mode), succ(exp_mode), 2'b00});
            end
            exp_mode = succ(exp_mode);
        end
        for (int f = 0; f < AUTO_FRAMES - 2; f++) begin
            idle(4);
            frame();
        end
        auto_en = 1'b0;
        step();
        auto_en = 1'b1;
        for (int f = 0; f < AUTO_FRAMES - 1; f++) begin
            idle(4);
            frame();
        end
        auto_en = 1'b0;
        idle(2);
        vectors++;
        if ({busy, mode_sel} !== {1'b0, exp_mode}) begin
            miscompares++;
            $display("FAIL auto_disable_clear: got busy/mode=%b want %b", {busy, mode_sel}, {1'b0, exp_mode});
        end
    endtask

    task automatic test_timeout_and_reset();
        int n;
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        for (int i = 0; i < BLANK_FRAMES + 1; i++) begin
            idle(3);
            frame();
        end
        vectors++;
        if ({load_req, mode_sel} !== {1'b1, succ(exp_mode)}) begin
            miscompares++;
            $display("FAIL to_load: got load/mode=%b want %b", {load_req, mode_sel}, {1'b1, succ(exp_mode)});
        end
        n = 0;
        while (err_pulse !== 1'b1 && n < ACK_TIMEOUT + 100) begin
            step();
            n++;
        end
        vectors++;
        if (n != ACK_TIMEOUT) begin
            miscompares++;
            $display("FAIL to_latency: got %0d cycles want %0d", n, ACK_TIMEOUT);
        end
        vectors++;
        if ({mode_sel, load_req, blank} !== {exp_mode, 2'b01}) begin
            miscompares++;
            $display("FAIL to_revert: got mode/load/blank=%b want %b", {mode_sel, load_req, blank}, {exp_mode, 2'b01});
        end
        step();
        vectors++;
        if (err_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL to_err_single: got %b want 0", err_pulse);
        end
        idle(3);
        frame();
        vectors++;
        if ({busy, blank, mode_sel} !== {2'b00, exp_mode}) begin
            miscompares++;
            $display("FAIL to_unblank: got busy/blank/mode=%b want %b", {busy, blank, mode_sel}, {2'b00, exp_mode});
        end
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        idle(2);
        frame();
        vectors++;
        if (blank !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_blank_entry: got %b want 1", blank);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        vectors++;
        if ({mode_sel, load_req, blank, busy, cmd_ready, err_pulse} !== 7'b01_0001_0) begin
            miscompares++;
            $display("FAIL rst_mid_blank: got %b want %b",
                     {mode_sel, load_req, blank, busy, cmd_ready, err_pulse}, 7'b01_0001_0);
        end
        step();
        sys_rst_n = 1'b1;
        for (int i = 0; i < BLANK_FRAMES + 2; i++) begin
            idle(3);
            frame();
        end
        vectors++;
        if ({mode_sel, load_req, blank, busy} !== 5'b01_000) begin
            miscompares++;
            $display("FAIL rst_stays_idle: got %b want 01000", {mode_sel, load_req, blank, busy});
        end
        exp_mode = 2'd1;
    endtask

    task automatic test_back_to_back_random();
        logic b1, ld, ld_post, b_fin, busy_fin;
        logic [1:0] md, md_fin, m, tgt;
        logic has_cmd, sw, er;
        int src;
        for (int it = 0; it < 24; it++) begin
            src = int'($urandom_range(0, 3));
            m = 2'($urandom_range(0, 3));
            has_cmd = (src == 0) || (src == 2);
            if (has_cmd) begin
                tgt = m;
                sw = (m != 2'd0) && (m != exp_mode);
                er = (m == 2'd0);
            end else begin
                tgt = succ(exp_mode);
                sw = 1'b1;
                er = 1'b0;
            end
            cmd_valid = has_cmd;
            cmd_mode = m;
            btn_next = (src != 0);
            frame_start = (src == 3);
            step();
            cmd_valid = 1'b0;
            btn_next = 1'b0;
            frame_start = 1'b0;
            vectors++;
            if ({busy, err_pulse, blank} !== {sw, er, 1'b0}) begin
                miscompares++;
                $display("FAIL rnd_capture: iter %0d src %0d got busy/err/blank=%b want %b",
                         it, src, {busy, err_pulse, blank}, {sw, er, 1'b0});
            end
            if (sw) begin
                drive_switch(int'($urandom_range(2, 12)), int'($urandom_range(0, 5)),
                             b1, ld, md, ld_post, b_fin, busy_fin, md_fin);
                vectors++;
                if ({b1, ld, md, ld_post, b_fin, busy_fin, md_fin} !== {2'b11, tgt, 3'b000, tgt}) begin
                    miscompares++;
                    $display("FAIL rnd_switch: iter %0d got %b want %b", it,
                             {b1, ld, md, ld_post, b_fin, busy_fin, md_fin}, {2'b11, tgt, 3'b000, tgt});
                end
                exp_mode = tgt;
            end else begin
                idle(2);
                vectors++;
                if ({busy, mode_sel} !== {1'b0, exp_mode}) begin
                    miscompares++;
                    $display("FAIL rnd_noswitch: iter %0d got busy/mode=%b want %b",
                             it, {busy, mode_sel}, {1'b0, exp_mode});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_button();
        test_priority();
        test_illegal_cmd();
        test_auto_cycle();
        test_timeout_and_reset();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
